control_sequencer: RTL
======================

// Module: control_sequencer
// PURPOSE
//  Parametrised step sequencer driving the datapath control inputs (GPRin/GPRout, PCin, IRin, RYin, RZin,
//  MARin, MDRin, HIin, LOin, Read, *out selects, ALU op strobes). Runs fetch (T0-T2) and execute (T3-T6)
//  for register-register ALU instructions. Replaces hand-driven bench stimulus; sits beside datapath and reads IRVal.
// PARAMETERS
//  BITS       32  datapath/instruction width
//  REGISTERS  16  general-purpose register count; RW = $clog2(REGISTERS) bits per register field
//  OPW        5   opcode field width
// PORTS
//  Clock      in   1          single clock, rising edge
//  reset      in   1          synchronous, active-high
//  run        in   1          level; 1 = fetch/execute continuously; 0 = stop at next instruction boundary
//  mem_ready  in   1          memory read complete (sampled in T1)
//  IRVal      in   BITS       IR contents: op=[BITS-1 -: OPW], Ra/Rb/Rc = next three RW-bit fields downward
//  PCout,Zlowout,Zhighout,MDRout  out 1  bus drive selects
//  MARin,RZin,PCin,MDRin,IRin,RYin,HIin,LOin  out 1  register load enables
//  IncPC,Read out  1          PC increment / memory read
//  GPRin,GPRout out REGISTERS one-hot register load / bus drive
//  ADD,SUB,AND,OR,SHR,SHL,ROR,ROL,MUL,DIV,NEGATE,NOT  out 1  ALU op strobes (at most one high)
//  busy       out  1          high in T0..T6
//  done       out  1          one-cycle pulse in an instruction's final step
//  illegal    out  1          one-cycle pulse, undefined opcode
//  halted     out  1          high in HALT
// BEHAVIOUR
//  - States: IDLE, T0..T6, HALT. Outputs are Moore decodes of state plus IRVal (IRVal valid from T3).
//  - Reset (any state, mid-instruction included): next state IDLE; every output 0 in IDLE.
//  - IDLE: run=1 -> T0; else stay.
//  - T0: PCout, MARin, IncPC, RZin.  -> T1
//  - T1: Zlowout, PCin, Read, MDRin. mem_ready=0 -> stay T1 (PCin only in first T1 cycle); mem_ready=1 -> T2
//  - T2: MDRout, IRin. -> T3
//  - T3 decode op: 0 ADD,1 SUB,2 AND,3 OR,4 SHR,5 SHL,6 ROR,7 ROL,8 MUL,9 DIV,10 NEGATE,11 NOT, all-ones HALT.
//     valid ALU op: GPRout[Rb], RYin -> T4.  HALT: -> HALT, no strobes.
//     any other op: illegal=1, done=1 -> T0 if run else IDLE.
//  - T4: binary op GPRout[Rc]; unary (NEGATE/NOT) GPRout[Rb]; op strobe, RZin. -> T5
//  - T5: MUL/DIV: Zlowout, LOin -> T6.  others: Zlowout, GPRin[Ra], done -> T0 if run else IDLE.
//  - T6 (MUL/DIV only): Zhighout, HIin, done -> T0 if run else IDLE. Ra ignored for MUL/DIV.
//  - HALT: halted=1, all else 0; leaves only on reset.
//  - Register fields >= REGISTERS: GPRin/GPRout stay all-zero for that access, no illegal pulse.
//  - run sampled only at instruction boundaries; deassertion mid-instruction completes the instruction.
//  - Latency with mem_ready=1 in T1: ALU op 6 cycles T0->T5, MUL/DIV 7 cycles; each mem wait adds 1.
//  - Invariants: at most one bus driver (PCout/Zlowout/Zhighout/MDRout/GPRout bit) high per cycle;
//    GPRin, GPRout each one-hot or zero.
// TESTING (BITS=32, REGISTERS=16, OPW=5)
//  1 reset=1 two cycles, run=1 -> all outputs 0, state IDLE; after release T0 next cycle (PCout=MARin=IncPC=RZin=1).
//  2 IRVal=0x00918000 (ADD R1,R2,R3), mem_ready=1 -> GPRout=0x0004 in T3, 0x0008 + ADD in T4, GPRin=0x0002 + done in T5.
//  3 IRVal=0x402B0000 (MUL R5,R6), run=1 -> LOin in T5, HIin+Zhighout+done in T6, next cycle T0.
//  4 mem_ready low 3 cycles in T1 -> Read/MDRin held 4 cycles, PCin high only first cycle, T2 follows.
//  5 IRVal=0x60000000 (op 12) -> illegal=done=1 in T3, T0 next; IRVal=0xF8000000 -> halted=1 until reset.
//  6 reset at T4 of ADD -> IDLE next cycle, op strobe/GPRout drop to 0; run=0 during T4 -> T5 completes, then IDLE.

Source files
------------

// File: rtl/control_sequencer.sv
// control_sequencer
//   Step sequencer for the register-register datapath. It walks fetch (T0-T2)
//   and execute (T3-T6) and decodes the control strobes from the current
//   step and the IR contents (IRVal). IRVal is valid from T3 onward.
//
// Ports
//   Clock, reset         rising-edge clock, synchronous active-high reset
//   run                  continue fetching; sampled only at instruction boundaries
//   mem_ready            memory read complete, sampled in T1
//   IRVal[BITS-1:0]      op = top OPW bits, then Ra, Rb, Rc (RW bits each)
//   PCout..MDRout        bus drive selects
//   MARin..LOin          register load enables
//   IncPC, Read          PC increment, memory read
//   GPRin, GPRout        one-hot (or zero) register load / bus drive
//   ADD..NOT             ALU op strobes, only in T4
//   busy, done, illegal, halted   status
//
// state  | meaning
// IDLE   | waiting for run, all outputs low
// T0     | PC to MAR, start PC increment into Z
// T1     | incremented PC back to PC, memory read (may wait)
// T2     | MDR to IR
// T3     | decode; first operand Rb to RY, or illegal/halt
// T4     | second operand on bus, ALU strobe, result to Z
// T5     | Zlow to Ra (or LO for MUL/DIV)
// T6     | Zhigh to HI (MUL/DIV only)
// HALT   | stopped until reset

module control_sequencer #(
    parameter int BITS      = 32,
    parameter int REGISTERS = 16,
    parameter int OPW       = 5
) (
    input  logic                 Clock,
    input  logic                 reset,
    input  logic                 run,
    input  logic                 mem_ready,
    input  logic [BITS-1:0]      IRVal,
    output logic                 PCout,
    output logic                 Zlowout,
    output logic                 Zhighout,
    output logic                 MDRout,
    output logic                 MARin,
    output logic                 RZin,
    output logic                 PCin,
    output logic                 MDRin,
    output logic                 IRin,
    output logic                 RYin,
    output logic                 HIin,
    output logic                 LOin,
    output logic                 IncPC,
    output logic                 Read,
    output logic [REGISTERS-1:0] GPRin,
    output logic [REGISTERS-1:0] GPRout,
    output logic                 ADD,
    output logic                 SUB,
    output logic                 AND,
    output logic                 OR,
    output logic                 SHR,
    output logic                 SHL,
    output logic                 ROR,
    output logic                 ROL,
    output logic                 MUL,
    output logic                 DIV,
    output logic                 NEGATE,
    output logic                 NOT,
    output logic                 busy,
    output logic                 done,
    output logic                 illegal,
    output logic                 halted
);

    localparam int RW = $clog2(REGISTERS);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_HALT
    } state_t;

    state_t state;
    logic   t1_wait;   // set after the first T1 cycle so PCin is a single pulse

    logic [OPW-1:0] op;
    logic [RW-1:0]  ra, rb, rc;
    logic           op_valid, is_halt, is_muldiv, is_unary, in_t4;

    assign op = IRVal[BITS-1 -: OPW];
    assign ra = IRVal[BITS-OPW-1 -: RW];
    assign rb = IRVal[BITS-OPW-RW-1 -: RW];
    assign rc = IRVal[BITS-OPW-2*RW-1 -: RW];

    logic unused_ir_bits;
    assign unused_ir_bits = ^IRVal[BITS-OPW-3*RW-1:0];

    assign op_valid  = op < OPW'(12);
    assign is_halt   = op == '1;
    assign is_muldiv = (op == OPW'(8)) || (op == OPW'(9));
    assign is_unary  = (op == OPW'(10)) || (op == OPW'(11));

    // Register fields that do not name a register decode to all-zero.
    function automatic logic [REGISTERS-1:0] reg_sel(input logic [RW-1:0] idx);
        logic [REGISTERS-1:0] sel;
        sel = '0;
        for (int i = 0; i < REGISTERS; i++)
            if (int'(idx) == i) sel[i] = 1'b1;
        return sel;
    endfunction

    always_ff @(posedge Clock) begin
        if (reset) begin
            state   <= S_IDLE;
            t1_wait <= 1'b0;
        end else begin
            t1_wait <= 1'b0;
            unique case (state)
                S_IDLE: if (run) state <= S_T0;
                S_T0:   state <= S_T1;
                S_T1: begin
                    if (mem_ready) state   <= S_T2;
                    else           t1_wait <= 1'b1;
                end
                S_T2:   state <= S_T3;
                S_T3: begin
                    if (is_halt)       state <= S_HALT;
                    else if (op_valid) state <= S_T4;
                    else               state <= run ? S_T0 : S_IDLE;
                end
                S_T4:   state <= S_T5;
                S_T5: begin
                    if (is_muldiv) state <= S_T6;
                    else           state <= run ? S_T0 : S_IDLE;
                end
                S_T6:   state <= run ? S_T0 : S_IDLE;
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // ALU strobes: T4 is only reachable with a valid op, so at most one fires.
    assign in_t4  = state == S_T4;
    assign ADD    = in_t4 && (op == OPW'(0));
    assign SUB    = in_t4 && (op == OPW'(1));
    assign AND    = in_t4 && (op == OPW'(2));
    assign OR     = in_t4 && (op == OPW'(3));
    assign SHR    = in_t4 && (op == OPW'(4));
    assign SHL    = in_t4 && (op == OPW'(5));
    assign ROR    = in_t4 && (op == OPW'(6));
    assign ROL    = in_t4 && (op == OPW'(7));
    assign MUL    = in_t4 && (op == OPW'(8));
    assign DIV    = in_t4 && (op == OPW'(9));
    assign NEGATE = in_t4 && (op == OPW'(10));
    assign NOT    = in_t4 && (op == OPW'(11));

    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; Zhighout = 1'b0; MDRout = 1'b0;
        MARin = 1'b0; RZin = 1'b0; PCin = 1'b0; MDRin = 1'b0; IRin = 1'b0;
        RYin = 1'b0; HIin = 1'b0; LOin = 1'b0; IncPC = 1'b0; Read = 1'b0;
        GPRin = '0; GPRout = '0;
        busy = 1'b0; done = 1'b0; illegal = 1'b0; halted = 1'b0;
        unique case (state)
            S_T0: begin
                busy = 1'b1; PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; RZin = 1'b1;
            end
            S_T1: begin
                busy = 1'b1; Zlowout = 1'b1; Read = 1'b1; MDRin = 1'b1;
                PCin = !t1_wait;
            end
            S_T2: begin
                busy = 1'b1; MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                busy = 1'b1;
                if (op_valid) begin
                    GPRout = reg_sel(rb);
                    RYin   = 1'b1;
                end else if (!is_halt) begin
                    illegal = 1'b1;
                    done    = 1'b1;
                end
            end
            S_T4: begin
                busy   = 1'b1; RZin = 1'b1;
                GPRout = is_unary ? reg_sel(rb) : reg_sel(rc);
            end
            S_T5: begin
                busy = 1'b1; Zlowout = 1'b1;
                if (is_muldiv) begin
                    LOin = 1'b1;
                end else begin
                    GPRin = reg_sel(ra);
                    done  = 1'b1;
                end
            end
            S_T6: begin
                busy = 1'b1; Zhighout = 1'b1; HIin = 1'b1; done = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule
